cu_step_decoder: RTL and testbench
==================================

# cu_step_decoder

Control-unit sequencer that drives the CPU's 5-bit T-step counter. It consumes the counter's current step and the fetched opcode byte, and produces the counter's enable/reset plus the fetch, memory-read and interrupt-acknowledge strobes. It handles single-byte, CB-prefixed, HALT, interrupt-dispatch and memory-stall cases. It sits beside the step counter in the control unit, between the memory interface and the instruction register.

## Interface
Parameters:
- STEPS_PER_MCYCLE, 4, T-steps per machine cycle; fetch occupies one M-cycle.
- INT_STEPS, 20, length of interrupt dispatch in steps.

Ports:
- i_Clk  in  1  system clock.
- i_Reset_n  in  1  reset; asynchronous, active-low.
- i_Step  in  5  current step from the step counter.
- i_Mem_Data  in  8  byte returned by memory.
- i_Mem_Ready  in  1  memory read data valid this cycle.
- i_Int_Pending  in  1  any enabled interrupt flag set.
- i_Ime  in  1  interrupt master enable.
- o_Step_Enable  out  1  step counter enable.
- o_Step_Reset  out  1  step counter synchronous reset-to-0.
- o_Mem_Rd  out  1  memory read request (fetch cycles).
- o_Ir_Load  out  1  instruction register load strobe.
- o_Pc_Inc  out  1  program-counter increment strobe.
- o_Int_Ack  out  1  interrupt dispatch complete, one cycle.
- o_Opcode  out  8  latched opcode.
- o_Cb_Mode  out  1  latched opcode is CB-page.
- o_State  out  3  current state, for debug.

## Operation
- States: SYNC, FETCH, EXEC, CB_FETCH, CB_EXEC, HALT, INT, LOCK.
- Reset: state=SYNC, opcode=0x00, Cb_Mode=0. All strobes are 0, except o_Step_Enable=1 and o_Step_Reset=1, which force the counter to 0.
- SYNC -> FETCH after one cycle.
- FETCH, steps 0..3: o_Mem_Rd=1.
  - At step 3 with i_Mem_Ready: o_Ir_Load=1, o_Pc_Inc=1, and the opcode is latched from i_Mem_Data.
  - Next state depends on the latched byte:
    - 0xCB -> CB_FETCH.
    - illegal byte (D3,DB,DD,E3,E4,EB,EC,ED,F4,FC,FD) -> LOCK.
    - length == 4 -> end-of-instruction.
    - otherwise -> EXEC.
- CB_FETCH, steps 4..7: same as FETCH. At step 7 it latches the byte, sets Cb_Mode, then goes to CB_EXEC, or to end-of-instruction if the CB length is 8.
- EXEC/CB_EXEC: steps advance freely. At step == len-1 the block performs end-of-instruction.
- End-of-instruction: o_Step_Reset=1 with o_Step_Enable=1.
  - Next state priority: opcode 0x76 -> HALT; i_Int_Pending && i_Ime -> INT; else FETCH.
  - Cb_Mode clears on entry to FETCH.
- HALT: o_Step_Enable=0, o_Step_Reset=1.
  - On i_Int_Pending: go to INT if i_Ime, else FETCH.
- INT: runs INT_STEPS steps. At step INT_STEPS-1: o_Int_Ack=1 and end-of-instruction, then FETCH.
- LOCK: o_Step_Enable=0 until reset.
- Stall: whenever o_Mem_Rd=1 and i_Mem_Ready=0, o_Step_Enable=0 and state holds. Ir_Load/Pc_Inc stay 0.
- Length lookup: 5-bit unsigned step count, multiple of 4, range 4..24, including the fetch M-cycle. Examples: 0x00=4, 0x06=8, 0xC3=16, 0xCD=24, CB page r=8, CB (HL)=16.

## Timing
- State, opcode and Cb_Mode registers update on posedge i_Clk only when o_Step_Enable=1. In SYNC and HALT they update unconditionally.
- All outputs are combinational from registered state/opcode and i_Step, i_Mem_Ready, i_Int_Pending, i_Ime, i_Mem_Data. There is zero latency to the step counter.
- Step counter advances one step per enabled cycle. It returns to 0 on the cycle after o_Step_Reset.
- Stall on the last fetch step: hold step 3 until ready; load and advance happen in the same cycle.
- Interrupt arriving mid-instruction is ignored until end-of-instruction.
- Async reset mid-instruction returns to SYNC immediately. Strobes drop the same instant.

## Structure
- Package cu_pkg holds:
  - state enum (3-bit) plus SYNC..LOCK encodings;
  - illegal-opcode list;
  - FETCH_LEN=4 and INT_STEPS default.
- Sub-module cu_opcode_len: combinational {cb, opcode} -> 5-bit length. It is the only place lengths are defined.

## Test plan
- Reset release, memory returns 0x00 with ready -> SYNC 1 cycle, then o_Ir_Load at step 3, o_Step_Reset at step 3, next FETCH at step 0.
- Fetch 0x06 with ready held low for 3 cycles at step 3 -> o_Step_Enable=0 for 3 cycles. Then step 3 load, EXEC, o_Step_Reset at step 7.
- Fetch 0xCB then 0x37 -> o_Ir_Load at steps 3 and 7, o_Cb_Mode=1. o_Step_Reset at step 7, Cb_Mode=0 on the next FETCH.
- Fetch 0x76, i_Int_Pending raised 10 cycles later with i_Ime=1 -> HALT holds the counter at 0. INT runs 20 steps, then o_Int_Ack one cycle at step 19, then FETCH.
- Same as above with i_Ime=0 -> HALT -> FETCH, o_Int_Ack never asserts.
- Fetch 0xD3 -> LOCK, o_Step_Enable=0 indefinitely. Assert i_Reset_n low mid-LOCK -> SYNC, o_Step_Reset=1.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the control-unit step decoder: state encoding,
// fixed step counts and the set of opcodes that lock up the core.
package cu_pkg;

    typedef enum logic [2:0] {
        SYNC     = 3'd0,
        FETCH    = 3'd1,
        EXEC     = 3'd2,
        CB_FETCH = 3'd3,
        CB_EXEC  = 3'd4,
        HALT     = 3'd5,
        INT      = 3'd6,
        LOCK     = 3'd7
    } state_t;

    localparam logic [4:0] FETCH_LEN         = 5'd4;
    localparam int         INT_STEPS_DEFAULT = 20;
    localparam logic [7:0] OP_CB_PREFIX      = 8'hCB;
    localparam logic [7:0] OP_HALT           = 8'h76;

    // Unused slots of the main opcode page; fetching one hangs the core.
    function automatic logic is_illegal(input logic [7:0] op);
        case (op)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: is_illegal = 1'b1;
            default:                           is_illegal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cu_opcode_len.sv
// Instruction length in T-steps, fetch M-cycle(s) included. Decoded from the
// x/y/z fields of the opcode; the CB page only depends on the operand field.
module cu_opcode_len
    import cu_pkg::*;
(
    input  logic       i_Cb,
    input  logic [7:0] i_Opcode,
    output logic [4:0] o_Len
);

    logic [1:0] w_x;
    logic [2:0] w_y;
    logic [2:0] w_z;

    assign w_x = i_Opcode[7:6];
    assign w_y = i_Opcode[5:3];
    assign w_z = i_Opcode[2:0];

    always_comb begin
        o_Len = FETCH_LEN;
        if (i_Cb) begin
            o_Len = (w_z == 3'd6) ? 5'd16 : 5'd8;
        end else begin
            case (w_x)
                2'd0: begin
                    case (w_z)
                        3'd0: o_Len = (w_y == 3'd1) ? 5'd20 :
                                      ((w_y == 3'd0) || (w_y == 3'd2)) ? 5'd4 : 5'd12;
                        3'd1: o_Len = w_y[0] ? 5'd8 : 5'd12;
                        3'd2: o_Len = 5'd8;
                        3'd3: o_Len = 5'd8;
                        3'd4: o_Len = (w_y == 3'd6) ? 5'd12 : 5'd4;
                        3'd5: o_Len = (w_y == 3'd6) ? 5'd12 : 5'd4;
                        3'd6: o_Len = (w_y == 3'd6) ? 5'd12 : 5'd8;
                        default: o_Len = 5'd4;
                    endcase
                end
                2'd1: begin
                    if (i_Opcode == OP_HALT) begin
                        o_Len = 5'd4;
                    end else begin
                        o_Len = ((w_y == 3'd6) || (w_z == 3'd6)) ? 5'd8 : 5'd4;
                    end
                end
                2'd2: o_Len = (w_z == 3'd6) ? 5'd8 : 5'd4;
                default: begin
                    // Conditional control flow is budgeted at its taken length.
                    case (w_z)
                        3'd0: o_Len = (w_y < 3'd4) ? 5'd20 : (w_y == 3'd5) ? 5'd16 : 5'd12;
                        3'd1: o_Len = !w_y[0] ? 5'd12 : (w_y == 3'd5) ? 5'd4 :
                                      (w_y == 3'd7) ? 5'd8 : 5'd16;
                        3'd2: o_Len = (w_y < 3'd4) ? 5'd16 : w_y[0] ? 5'd16 : 5'd8;
                        3'd3: o_Len = (w_y == 3'd0) ? 5'd16 : 5'd4;
                        3'd4: o_Len = (w_y < 3'd4) ? 5'd24 : 5'd4;
                        3'd5: o_Len = !w_y[0] ? 5'd16 : (w_y == 3'd1) ? 5'd24 : 5'd4;
                        3'd6: o_Len = 5'd8;
                        default: o_Len = 5'd16;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/cu_step_decoder.sv
// Sequencer beside the T-step counter: turns the current step and fetched
// opcode into counter enable/reset plus fetch, IR-load and interrupt strobes.
module cu_step_decoder
    import cu_pkg::*;
#(
    parameter int STEPS_PER_MCYCLE = 4,
    parameter int INT_STEPS        = INT_STEPS_DEFAULT
) (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic [4:0] i_Step,
    input  logic [7:0] i_Mem_Data,
    input  logic       i_Mem_Ready,
    input  logic       i_Int_Pending,
    input  logic       i_Ime,
    output logic       o_Step_Enable,
    output logic       o_Step_Reset,
    output logic       o_Mem_Rd,
    output logic       o_Ir_Load,
    output logic       o_Pc_Inc,
    output logic       o_Int_Ack,
    output logic [7:0] o_Opcode,
    output logic       o_Cb_Mode,
    output logic [2:0] o_State
);

    localparam logic [4:0] FETCH_LAST    = 5'(STEPS_PER_MCYCLE - 1);
    localparam logic [4:0] CB_FETCH_LAST = 5'(2 * STEPS_PER_MCYCLE - 1);
    localparam logic [4:0] CB_FETCH_LEN  = 5'(2 * STEPS_PER_MCYCLE);
    localparam logic [4:0] INT_LAST      = 5'(INT_STEPS - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_opcode;
    logic [7:0] w_next_opcode;
    logic       r_cb;
    logic       w_next_cb;
    logic       w_fetching;
    logic       w_lu_cb;
    logic [7:0] w_lu_op;
    logic [4:0] w_len;
    logic       w_eoi;
    logic       w_update;

    // While fetching, the length must come from the byte on the bus, not the latch.
    assign w_fetching = (r_state == FETCH) || (r_state == CB_FETCH);
    assign w_lu_cb    = (r_state == CB_FETCH) || ((r_state != FETCH) && r_cb);
    assign w_lu_op    = w_fetching ? i_Mem_Data : r_opcode;

    cu_opcode_len u_len (
        .i_Cb     (w_lu_cb),
        .i_Opcode (w_lu_op),
        .o_Len    (w_len)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_opcode = r_opcode;
        w_next_cb     = r_cb;
        w_eoi         = 1'b0;
        o_Step_Enable = 1'b0;
        o_Step_Reset  = 1'b0;
        o_Mem_Rd      = 1'b0;
        o_Ir_Load     = 1'b0;
        o_Pc_Inc      = 1'b0;
        o_Int_Ack     = 1'b0;

        case (r_state)
            SYNC: begin
                o_Step_Enable = 1'b1;
                o_Step_Reset  = 1'b1;
                w_next_state  = FETCH;
            end
            FETCH, CB_FETCH: begin
                o_Mem_Rd = 1'b1;
                if (i_Mem_Ready) begin
                    o_Step_Enable = 1'b1;
                    if ((r_state == FETCH) && (i_Step == FETCH_LAST)) begin
                        o_Ir_Load     = 1'b1;
                        o_Pc_Inc      = 1'b1;
                        w_next_opcode = i_Mem_Data;
                        if (i_Mem_Data == OP_CB_PREFIX) begin
                            w_next_state = CB_FETCH;
                        end else if (is_illegal(i_Mem_Data)) begin
                            w_next_state = LOCK;
                        end else if (w_len == FETCH_LEN) begin
                            w_eoi = 1'b1;
                        end else begin
                            w_next_state = EXEC;
                        end
                    end else if ((r_state == CB_FETCH) && (i_Step == CB_FETCH_LAST)) begin
                        o_Ir_Load     = 1'b1;
                        o_Pc_Inc      = 1'b1;
                        w_next_opcode = i_Mem_Data;
                        w_next_cb     = 1'b1;
                        if (w_len == CB_FETCH_LEN) begin
                            w_eoi = 1'b1;
                        end else begin
                            w_next_state = CB_EXEC;
                        end
                    end
                end
            end
            EXEC, CB_EXEC: begin
                o_Step_Enable = 1'b1;
                w_eoi         = (i_Step == (w_len - 5'd1));
            end
            HALT: begin
                o_Step_Reset = 1'b1;
                if (i_Int_Pending) begin
                    w_next_state = i_Ime ? INT : FETCH;
                end
            end
            INT: begin
                o_Step_Enable = 1'b1;
                if (i_Step == INT_LAST) begin
                    o_Int_Ack    = 1'b1;
                    o_Step_Reset = 1'b1;
                    w_next_state = FETCH;
                end
            end
            default: begin
            end
        endcase

        // HALT outranks a pending interrupt; CB-page 0x76 is a BIT op, not HALT.
        if (w_eoi) begin
            o_Step_Enable = 1'b1;
            o_Step_Reset  = 1'b1;
            if (!w_next_cb && (w_next_opcode == OP_HALT)) begin
                w_next_state = HALT;
            end else if (i_Int_Pending && i_Ime) begin
                w_next_state = INT;
            end else begin
                w_next_state = FETCH;
            end
        end

        if (w_next_state == FETCH) begin
            w_next_cb = 1'b0;
        end
    end

    assign w_update = o_Step_Enable || (r_state == SYNC) || (r_state == HALT);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state  <= SYNC;
            r_opcode <= 8'h00;
            r_cb     <= 1'b0;
        end else if (w_update) begin
            r_state  <= w_next_state;
            r_opcode <= w_next_opcode;
            r_cb     <= w_next_cb;
        end
    end

    assign o_Opcode  = r_opcode;
    assign o_Cb_Mode = r_cb;
    assign o_State   = r_state;

endmodule

// File: tb/tb_cu_step_decoder.sv
// Bench for cu_step_decoder: an external step counter plus an instruction-level
// model that predicts every cycle from opcode length, stalls and interrupts.
module tb_cu_step_decoder;

    localparam int INT_STEPS = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] step;
    logic [7:0] mem_data = 8'h00;
    logic       mem_ready = 1'b0;
    logic       int_pending = 1'b0;
    logic       ime = 1'b0;
    logic       en, srst, rd, ld, pc, ack;
    logic [7:0] opcode;
    logic       cb_mode;
    logic [2:0] state;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_op = 8'h00;
    logic       exp_cb = 1'b0;

    logic [7:0] bad_list [11] = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                                  8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};

    always #5 clk = ~clk;

    cu_step_decoder dut (
        .i_Clk         (clk),
        .i_Reset_n     (rst_n),
        .i_Step        (step),
        .i_Mem_Data    (mem_data),
        .i_Mem_Ready   (mem_ready),
        .i_Int_Pending (int_pending),
        .i_Ime         (ime),
        .o_Step_Enable (en),
        .o_Step_Reset  (srst),
        .o_Mem_Rd      (rd),
        .o_Ir_Load     (ld),
        .o_Pc_Inc      (pc),
        .o_Int_Ack     (ack),
        .o_Opcode      (opcode),
        .o_Cb_Mode     (cb_mode),
        .o_State       (state)
    );

    // The T-step counter the decoder steers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     step <= 5'd0;
        else if (srst)  step <= 5'd0;
        else if (en)    step <= step + 5'd1;
    end

    function automatic bit is_bad(input logic [7:0] op);
        for (int i = 0; i < 11; i++) if (bad_list[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Lengths known from the opcode table: NOP, LD B,d8, JP, CALL, HALT, CB page.
    function automatic int model_len(input logic [7:0] op, input logic [7:0] cbop);
        case (op)
            8'h06:   return 8;
            8'hC3:   return 16;
            8'hCD:   return 24;
            8'hCB:   return (cbop[2:0] == 3'd6) ? 16 : 8;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe vector order: {enable, reset, mem_rd, ir_load, pc_inc, int_ack}.
    task automatic check_now(input string tag, input logic [4:0] e_step,
                             input logic [2:0] e_state, input logic [5:0] e_strb);
        check({tag, "/step"},   16'(step), 16'(e_step));
        check({tag, "/state"},  16'(state), 16'(e_state));
        check({tag, "/strobe"}, 16'({en, srst, rd, ld, pc, ack}), 16'(e_strb));
        check({tag, "/opcode"}, 16'({opcode, cb_mode}), 16'({exp_op, exp_cb}));
    endtask

    task automatic cyc(input string tag, input logic rdy, input logic [7:0] data,
                       input logic pend, input logic m, input logic [4:0] e_step,
                       input logic [2:0] e_state, input logic [5:0] e_strb);
        @(negedge clk);
        mem_ready = rdy;
        mem_data = data;
        int_pending = pend;
        ime = m;
        #1;
        check_now($sformatf("%s@%0d", tag, e_step), e_step, e_state, e_strb);
    endtask

    task automatic run_int();
        for (int s = 0; s < INT_STEPS; s++) begin
            logic last;
            last = (s == INT_STEPS - 1);
            cyc("int", 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                5'(s), 3'd6, {1'b1, last, 3'b000, last});
        end
        exp_cb = 1'b0;
    endtask

    task automatic run_halt(input int wait_n, input logic wake_ime);
        for (int i = 0; i < wait_n; i++)
            cyc("halt", 1'($urandom), 8'($urandom), 1'b0, 1'($urandom), 5'd0, 3'd5, 6'b010000);
        cyc("halt_wake", 1'($urandom), 8'($urandom), 1'b1, wake_ime, 5'd0, 3'd5, 6'b010000);
        if (wake_ime) run_int();
    endtask

    task automatic run_instr(input logic [7:0] op, input logic [7:0] cbop, input logic pend_e,
                             input logic ime_e, input int stall_last, input bit rnd,
                             input int halt_wait);
        int         len;
        int         last_fetch;
        int         ns;
        bit         cb;
        bit         bad;
        logic       eoi;
        logic       load;
        logic       p;
        logic       m;
        logic [7:0] d;
        logic [2:0] st;
        len = model_len(op, cbop);
        cb = (op == 8'hCB);
        bad = is_bad(op);
        last_fetch = cb ? 7 : 3;
        for (int s = 0; s <= last_fetch; s++) begin
            st = (s < 4) ? 3'd1 : 3'd3;
            ns = rnd ? $urandom_range(0, 2) : ((s == 3) ? stall_last : 0);
            for (int k = 0; k < ns; k++)
                cyc("stall", 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 5'(s), st, 6'b001000);
            eoi = (s == len - 1) && !bad;
            load = (s == 3) || (s == 7);
            d = (s == 3) ? op : (s == 7) ? cbop : 8'($urandom);
            p = eoi ? pend_e : 1'($urandom);
            m = eoi ? ime_e : 1'($urandom);
            cyc("fetch", 1'b1, d, p, m, 5'(s), st, {1'b1, eoi, 1'b1, load, load, 1'b0});
            if (s == 3) exp_op = op;
            if (s == 7) begin
                exp_op = cbop;
                exp_cb = 1'b1;
            end
        end
        if (bad) return;
        for (int s = last_fetch + 1; s < len; s++) begin
            eoi = (s == len - 1);
            p = eoi ? pend_e : 1'($urandom);
            m = eoi ? ime_e : 1'($urandom);
            cyc("exec", 1'($urandom), 8'($urandom), p, m, 5'(s), cb ? 3'd4 : 3'd2,
                {1'b1, eoi, 4'b0000});
        end
        if (op == 8'h76) run_halt(halt_wait, ime_e);
        else if (pend_e && ime_e) run_int();
        else exp_cb = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_now("sync", 5'd0, 3'd0, 6'b110000);
    endtask

    task automatic lock_then_reset(input int n);
        for (int i = 0; i < n; i++)
            cyc("lock", 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 5'd4, 3'd7, 6'b000000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_op = 8'h00;
        exp_cb = 1'b0;
        check_now("lock_reset", 5'd0, 3'd0, 6'b110000);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_now("reset", 5'd0, 3'd0, 6'b110000);
        release_reset();

        run_instr(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0, 0);
        run_instr(8'h06, 8'h00, 1'b0, 1'b0, 3, 1'b0, 0);
        run_instr(8'hCB, 8'h37, 1'b0, 1'b0, 0, 1'b0, 0);
        run_instr(8'h76, 8'h00, 1'b1, 1'b1, 0, 1'b0, 10);
        run_instr(8'h76, 8'h00, 1'b0, 1'b0, 0, 1'b0, 10);
        run_instr(8'hCD, 8'h00, 1'b1, 1'b1, 0, 1'b0, 0);
        run_instr(8'hC3, 8'h00, 1'b1, 1'b0, 0, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] op;
            logic [7:0] cbop;
            cbop = 8'($urandom);
            case ($urandom_range(0, 5))
                0:       op = 8'h00;
                1:       op = 8'h06;
                2:       op = 8'hC3;
                3:       op = 8'hCD;
                4:       op = 8'hCB;
                default: op = 8'h76;
            endcase
            run_instr(op, cbop, ($urandom_range(0, 3) == 0), 1'($urandom), 0, 1'b1,
                      $urandom_range(0, 6));
        end

        run_instr(8'hD3, 8'h00, 1'b0, 1'b0, 0, 1'b0, 0);
        lock_then_reset(6);
        release_reset();
        run_instr(bad_list[$urandom_range(0, 10)], 8'h00, 1'b0, 1'b0, 0, 1'b1, 0);
        lock_then_reset(3);
        release_reset();
        run_instr(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
